// File: rtl/nn_pkg.sv
// nn_pkg: shared types and constants for the NN MAC datapath.
package nn_pkg;
   typedef enum logic {ACC = 1'b0, OUT = 1'b1} nn_state_e;
   localparam int NN_WIDTH = 5;
   function automatic longint acc_max(input int w);
      return (longint'(1) <<< (w - 1)) - 1;
   endfunction
   function automatic longint acc_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction
endpackage

// File: rtl/nn_sat_add.sv
// nn_sat_add: adds a sign-extended product to an accumulator and clamps the
// sum to the signed ACC_WIDTH range, flagging when a clamp happens.
module nn_sat_add import nn_pkg::*; #(
   parameter int ACC_WIDTH  = 16,
   parameter int PROD_WIDTH = 10
) (
   input  logic signed [ACC_WIDTH-1:0]  acc,
   input  logic signed [PROD_WIDTH-1:0] prod,
   output logic signed [ACC_WIDTH-1:0]  sum,
   output logic                         sat
);
   localparam logic signed [ACC_WIDTH-1:0] MAX_V = ACC_WIDTH'(acc_max(ACC_WIDTH));
   localparam logic signed [ACC_WIDTH-1:0] MIN_V = ACC_WIDTH'(acc_min(ACC_WIDTH));
   logic signed [ACC_WIDTH:0] raw;
   always_comb begin
      raw = {acc[ACC_WIDTH-1], acc} + {{(ACC_WIDTH + 1 - PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod};
      // Both operands fit ACC_WIDTH bits, so overflow shows as the top two bits disagreeing.
      sat = raw[ACC_WIDTH] != raw[ACC_WIDTH-1];
      sum = !sat ? raw[ACC_WIDTH-1:0] : raw[ACC_WIDTH] ? MIN_V : MAX_V;
   end
endmodule

// File: rtl/nn_mac_neuron.sv
// nn_mac_neuron: handshaked streaming signed MAC with saturation, one result per
// in_last-framed vector. Define NN_MAC_RELU_EN to clamp negative results to 0.
module nn_mac_neuron import nn_pkg::*; #(
   parameter int WIDTH     = NN_WIDTH,
   parameter int ACC_WIDTH = 16,
   parameter int CNT_WIDTH = 8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic signed [WIDTH-1:0]     in_a,
   input  logic signed [WIDTH-1:0]     in_b,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [ACC_WIDTH-1:0] out_data,
   output logic [CNT_WIDTH-1:0]        out_count,
   output logic                        out_sat
);
   localparam int PW = 2 * WIDTH;
   nn_state_e state_q, state_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d, sum, res, out_data_q, out_data_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc, out_count_q, out_count_d;
   logic sat_q, sat_d, add_sat, out_sat_q, out_sat_d, out_valid_q, out_valid_d;
   logic beat, take, latch;
   logic signed [PW-1:0] prod;

   assign prod = PW'(in_a) * PW'(in_b);

   nn_sat_add #(.ACC_WIDTH(ACC_WIDTH), .PROD_WIDTH(PW)) u_add (
      .acc  (acc_q),
      .prod (prod),
      .sum  (sum),
      .sat  (add_sat)
   );

   always_comb begin
      beat    = in_valid && state_q == ACC;
      take    = state_q == OUT && out_ready;
      latch   = beat && in_last;
      cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_WIDTH'(1);
`ifdef NN_MAC_RELU_EN
      res = sum[ACC_WIDTH-1] ? '0 : sum;
`else
      res = sum;
`endif
      acc_d       = take ? '0 : beat ? sum : acc_q;
      cnt_d       = take ? '0 : beat ? cnt_inc : cnt_q;
      sat_d       = take ? 1'b0 : beat ? (sat_q | add_sat) : sat_q;
      out_data_d  = latch ? res : out_data_q;
      out_count_d = latch ? cnt_inc : out_count_q;
      out_sat_d   = latch ? (sat_q | add_sat) : out_sat_q;
      out_valid_d = latch | (out_valid_q & ~take);
      state_d     = latch ? OUT : take ? ACC : state_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ACC;
         acc_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_sat_q   <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sat_q       <= sat_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_sat_q   <= out_sat_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = state_q == ACC;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_nn_mac_neuron.sv
// tb_nn_mac_neuron: directed vectors with a result scoreboard for nn_mac_neuron
// (ACC_WIDTH=10); expectations follow NN_MAC_RELU_EN when it is defined.
module tb_nn_mac_neuron;
   localparam int W = 5, AW = 10, CW = 8;
   logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 1;
   logic signed [W-1:0] in_a = '0, in_b = '0;
   logic in_ready, out_valid, out_sat;
   logic signed [AW-1:0] out_data;
   logic [CW-1:0] out_count;
   typedef struct packed {
      logic signed [AW-1:0] d;
      logic [CW-1:0]        c;
      logic                 s;
   } exp_t;
   exp_t sb[$];
   int errors = 0, checks = 0;

   nn_mac_neuron #(.WIDTH(W), .ACC_WIDTH(AW), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_count(out_count), .out_sat(out_sat)
   );

   always #5 clk = ~clk;

   function automatic logic signed [AW-1:0] act(input int v);
`ifdef NN_MAC_RELU_EN
      return v < 0 ? '0 : AW'(v);
`else
      return AW'(v);
`endif
   endfunction

   task automatic chk(input string n, input logic signed [63:0] got, input logic signed [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, got, want);
      end
   endtask

   task automatic expect_vec(input int d, input int c, input logic s);
      sb.push_back(exp_t'{act(d), CW'(c), s});
   endtask

   task automatic beat(input int a, input int b, input logic last);
      int n = 0;
      in_a = W'(a);
      in_b = W'(b);
      in_last = last;
      in_valid = 1;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (n == 100) chk("in_ready_timeout", 0, 1);
      @(posedge clk); #1;
      in_valid = 0;
      in_last = 0;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         if (sb.size() == 0) chk("unexpected_result", 1, 0);
         else begin
            e = sb.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_count", out_count, e.c);
            chk("out_sat", out_sat, e.s);
         end
      end
   end

   initial begin
      int n;
      in_valid = 1'($urandom);
      in_last = 1'($urandom);
      in_a = W'($urandom);
      in_b = W'($urandom);
      out_ready = 1'($urandom);
      #12;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_count", out_count, 0);
      chk("rst_out_sat", out_sat, 0);
      in_valid = 0; in_last = 0; in_a = '0; in_b = '0; out_ready = 1;
      @(posedge clk); #1;
      rst_n = 1;

      expect_vec(-24, 1, 0);
      beat(2, -12, 1);
      chk("latency_valid", out_valid, 1);

      expect_vec(-84, 3, 0);
      beat(2, -12, 0);
      beat(1, 0, 0);
      beat(15, -4, 1);
      chk("out_state_valid", out_valid, 1);
      chk("out_state_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("dwell_in_ready", in_ready, 1);
      chk("dwell_out_valid", out_valid, 0);

      out_ready = 0;
      expect_vec(9, 1, 0);
      beat(3, 3, 1);
      in_a = 7; in_b = 7; in_last = 1; in_valid = 1;
      repeat (4) begin
         chk("bp_valid", out_valid, 1);
         chk("bp_data", out_data, act(9));
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
      end
      in_valid = 0; in_last = 0; out_ready = 1;
      expect_vec(1, 1, 0);
      beat(1, 1, 1);

      expect_vec(511, 4, 1);
      repeat (3) beat(15, 15, 0);
      beat(15, 15, 1);
      expect_vec(1, 1, 0);
      beat(1, 1, 1);

      expect_vec(-512, 3, 1);
      repeat (2) beat(-16, 15, 0);
      beat(-16, 15, 1);

      expect_vec(1, 255, 0);
      repeat (256) beat(0, 0, 0);
      beat(1, 1, 1);

      beat(5, 5, 0);
      beat(5, 5, 0);
      #2 rst_n = 0;
      #1;
      chk("midrst_out_valid", out_valid, 0);
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_out_count", out_count, 0);
      @(posedge clk); #1;
      rst_n = 1;
      repeat (3) begin
         @(posedge clk); #1;
         chk("midrst_no_result", out_valid, 0);
      end
      expect_vec(256, 1, 0);
      beat(-16, -16, 1);

      n = 0;
      while (sb.size() > 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      chk("scoreboard_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
